l1a_match_queue: RTL and testbench
==================================

Name: l1a_match_queue

Overview:
- Consumes the per-L1A match verdicts from the trigger-match register (MATCHR / NO_MATCH, one pulse per L1A).
- Tags each verdict with a running L1A event number and queues it for the readout controller.
- Presents queue entries through a valid/ready handshake.
- Reports overflow, protocol-error and readout-stall status to the control registers.

Parameters:
DEPTH, 8, queue depth in entries; power of 2, range 4..64
L1N_W, 12, width of the L1A event number
TO_W, 10, width of the stall timeout counter; stall declared after 2^TO_W cycles

Ports:
CLK  input  1  system clock
RST  input  1  reset, asynchronous, active-high
L1N_RST  input  1  synchronous L1A-number reset; takes effect on the next edge
MATCHR  input  1  single-cycle pulse: current L1A matched an LCT
NO_MATCH  input  1  single-cycle pulse: current L1A had no LCT match
EVT_READY  input  1  readout accepts the presented entry this cycle
EVT_VALID  output  1  an entry is presented
EVT_MATCH  output  1  match flag of the presented entry
EVT_L1N  output  L1N_W  L1A number of the presented entry
COUNT  output  clog2(DEPTH)+1  entries held, including the presented one
FULL  output  1  COUNT == DEPTH
OVERFLOW  output  1  sticky: a verdict was dropped
PROT_ERR  output  1  sticky: MATCHR and NO_MATCH asserted in the same cycle
STALL  output  1  sticky: EVT_VALID held without EVT_READY for 2^TO_W cycles

Behaviour:
- Reset: all outputs 0; pointers, L1N counter and timeout counter cleared. Reset mid-operation discards all entries immediately.
- push = MATCHR | NO_MATCH.
- Entry = {match, l1n}, where match = MATCHR.
- Simultaneous MATCHR & NO_MATCH:
  - push one entry with match = 1;
  - set PROT_ERR.
- L1N counter:
  - increments on every push, including dropped pushes;
  - wraps from 2^L1N_W-1 to 0;
  - the entry carries the pre-increment value.
- L1N_RST:
  - sets the counter to 0;
  - if push occurs in the same cycle, that entry carries 0 and the counter becomes 1.
- pop = EVT_VALID & EVT_READY.
- Latency: push into an empty queue gives EVT_VALID=1 on the next edge with the entry's data. EVT_MATCH/EVT_L1N are registered.
- While EVT_VALID=1 and EVT_READY=0, the outputs are held stable.
- Full handling:
  - push while FULL and no pop: entry dropped, OVERFLOW set, COUNT unchanged;
  - push and pop together while FULL: push accepted, COUNT stays DEPTH, no overflow.
- Empty handling: pop is impossible (EVT_VALID=0). EVT_READY while empty is ignored.
- Simultaneous push and pop, non-full: COUNT unchanged. The next entry is presented on the next edge with no bubble.
- Output FSM states:
  - EMPTY: EVT_VALID=0. Go to PRESENT when the storage is non-empty or a push occurs.
  - PRESENT: EVT_VALID=1. On pop, reload from storage if non-empty (stay in PRESENT), else go to EMPTY.
- Stall timeout:
  - counter increments each cycle in PRESENT with EVT_READY=0;
  - clears on pop or in EMPTY;
  - at terminal count, sets STALL; the counter saturates.
- Sticky flags (OVERFLOW, PROT_ERR, STALL) clear only on RST.
- Pointer arithmetic: clog2(DEPTH) bits, natural wrap. Full and empty are distinguished by COUNT, not by pointer equality.

Decomposition:
- Shared package holds:
  - L1N_W_DEF = 12;
  - entry type {match:1, l1n:L1N_W};
  - the FSM state encoding (EMPTY=1'b0, PRESENT=1'b1).
- One sub-module: sync_fifo_ram, a generic width/depth storage array with write enable, read address and registered read data.
- The pointers, COUNT, L1N counter, output FSM and status flags stay in l1a_match_queue.

Test Plan:
- Basic path: after reset, MATCHR pulse, then NO_MATCH pulse 3 cycles later, EVT_READY=1.
  -> EVT_VALID one cycle after each pulse, with {1,0x000} then {0,0x001}; COUNT returns to 0; no flags set.
- Backpressure and overflow: EVT_READY=0, 9 MATCHR pulses.
  -> FULL=1 after the 8th; 9th dropped; OVERFLOW=1; COUNT=8.
  -> Then release EVT_READY: entries drain with L1N 0..7; the next push carries L1N 9.
- Full plus simultaneous pop: with COUNT=8, push and pop in the same cycle.
  -> COUNT stays 8, OVERFLOW stays 0, the new entry is retained and read out last.
- Wrap and reset: preload the L1N counter by issuing 4095 pushes while draining, then push 2 more.
  -> entries carry L1N 0xFFF then 0x000.
  -> L1N_RST with a simultaneous push: that entry carries 0x000, the next entry 0x001.
- Protocol error: MATCHR and NO_MATCH both high for 1 cycle.
  -> one entry with match=1, PROT_ERR=1, L1N advances by 1.
- Stall and async reset: hold EVT_READY=0 with one entry for 1024 cycles.
  -> STALL=1 on cycle 1024.
  -> Assert RST asynchronously mid-cycle: all outputs 0 immediately, with no edge required.

Source files
------------

// File: rtl/l1a_match_queue_pkg.sv
// Shared types for the L1A match-verdict queue: entry layout and output FSM encoding.
package l1a_match_queue_pkg;

    localparam int unsigned L1N_W_DEF = 12;

    typedef struct packed {
        logic                 match;
        logic [L1N_W_DEF-1:0] l1n;
    } entry_t;

    typedef enum logic {
        StEmpty   = 1'b0,
        StPresent = 1'b1
    } state_e;

endpackage

// File: rtl/l1a_match_queue_if.sv
// Verdict input and readout handshake bundle; master is the queue, slave the surrounding logic.
interface l1a_match_queue_if #(
    parameter int unsigned L1N_W = 12
) ();

    logic             MATCHR;
    logic             NO_MATCH;
    logic             L1N_RST;
    logic             EVT_READY;
    logic             EVT_VALID;
    logic             EVT_MATCH;
    logic [L1N_W-1:0] EVT_L1N;

    modport master (
        input  MATCHR,
        input  NO_MATCH,
        input  L1N_RST,
        input  EVT_READY,
        output EVT_VALID,
        output EVT_MATCH,
        output EVT_L1N
    );

    modport slave (
        output MATCHR,
        output NO_MATCH,
        output L1N_RST,
        output EVT_READY,
        input  EVT_VALID,
        input  EVT_MATCH,
        input  EVT_L1N
    );

endinterface

// File: rtl/l1a_match_queue_sync_fifo_ram.sv
// Generic storage array with one write port and a registered read port.
module sync_fifo_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Write-first bypass so an entry written this cycle can be read out on the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/l1a_match_queue.sv
// Tags MATCHR/NO_MATCH verdicts with a running L1A number and queues them for readout,
// with sticky overflow, protocol-error and stall status.
module l1a_match_queue
    import l1a_match_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned L1N_W = L1N_W_DEF,
    parameter int unsigned TO_W  = 10
) (
    input  logic                   CLK,
    input  logic                   RST,
    l1a_match_queue_if.master      bus,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic                   FULL,
    output logic                   OVERFLOW,
    output logic                   PROT_ERR,
    output logic                   STALL
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = L1N_W + 1;

    typedef struct packed {
        logic             match;
        logic [L1N_W-1:0] l1n;
    } q_entry_t;

    state_e           state_q, state_d;
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [L1N_W-1:0] l1n_q, l1n_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             ovf_q, ovf_d, perr_q, perr_d, stall_q, stall_d;
    logic             push, pop, full, push_acc, rd_en;
    q_entry_t         wr_entry, rd_entry;
    logic [EW-1:0]    rd_data;

    assign push     = bus.MATCHR | bus.NO_MATCH;
    assign full     = (cnt_q == CW'(DEPTH));
    assign pop      = (state_q == StPresent) & bus.EVT_READY;
    // When full, a concurrent pop frees the presented slot, so the push still fits.
    assign push_acc = push & (~full | pop);

    assign wr_entry.match = bus.MATCHR;
    assign wr_entry.l1n   = bus.L1N_RST ? '0 : l1n_q;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        l1n_d   = l1n_q;
        to_d    = to_q;
        ovf_d   = ovf_q;
        perr_d  = perr_q;
        stall_d = stall_q;
        rd_en   = 1'b0;

        if (push_acc) wptr_d = wptr_q + AW'(1);
        if (pop)      rptr_d = rptr_q + AW'(1);
        cnt_d = cnt_q + CW'(push_acc) - CW'(pop);

        if (push) begin
            l1n_d = wr_entry.l1n + L1N_W'(1);
        end else if (bus.L1N_RST) begin
            l1n_d = '0;
        end
        if (push && !push_acc)              ovf_d  = 1'b1;
        if (bus.MATCHR && bus.NO_MATCH)     perr_d = 1'b1;

        unique case (state_q)
            StEmpty: begin
                to_d = '0;
                if (push_acc) begin
                    rd_en   = 1'b1;
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (pop) begin
                    to_d  = '0;
                    rd_en = (cnt_d != '0);
                    if (cnt_d == '0) state_d = StEmpty;
                end else if (to_q == '1) begin
                    stall_d = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StEmpty;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            l1n_q   <= '0;
            to_q    <= '0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            l1n_q   <= l1n_d;
            to_q    <= to_d;
            ovf_q   <= ovf_d;
            perr_q  <= perr_d;
            stall_q <= stall_d;
        end
    end

    // The RAM read register doubles as the presented-entry register.
    sync_fifo_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (CLK),
        .rst_i   (RST),
        .we_i    (push_acc),
        .waddr_i (wptr_q),
        .wdata_i (wr_entry),
        .re_i    (rd_en),
        .raddr_i (rptr_d),
        .rdata_o (rd_data)
    );

    assign rd_entry      = q_entry_t'(rd_data);
    assign bus.EVT_VALID = (state_q == StPresent);
    assign bus.EVT_MATCH = rd_entry.match;
    assign bus.EVT_L1N   = rd_entry.l1n;
    assign COUNT         = cnt_q;
    assign FULL          = full;
    assign OVERFLOW      = ovf_q;
    assign PROT_ERR      = perr_q;
    assign STALL         = stall_q;

endmodule

// File: tb/tb_l1a_match_queue.sv
// Directed and random stimulus against a queue-based reference model of the verdict queue.
module tb_l1a_match_queue;
    import l1a_match_queue_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TO_W  = 10;
    localparam int unsigned L1N_W = L1N_W_DEF;
    localparam int          STALL_CYC = 1 << TO_W;
    localparam int          L1N_MOD   = 1 << L1N_W;

    logic                   CLK = 1'b0;
    logic                   RST = 1'b1;
    logic [$clog2(DEPTH):0] COUNT;
    logic                   FULL, OVERFLOW, PROT_ERR, STALL;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    entry_t mq[$];
    int     l1n_m;
    bit     ovf_m, perr_m, stall_m;
    int     run_m;

    l1a_match_queue_if #(.L1N_W(L1N_W)) bus ();

    l1a_match_queue #(
        .DEPTH (DEPTH),
        .L1N_W (L1N_W),
        .TO_W  (TO_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .bus      (bus),
        .COUNT    (COUNT),
        .FULL     (FULL),
        .OVERFLOW (OVERFLOW),
        .PROT_ERR (PROT_ERR),
        .STALL    (STALL)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        l1n_m   = 0;
        ovf_m   = 1'b0;
        perr_m  = 1'b0;
        stall_m = 1'b0;
        run_m   = 0;
    endtask

    task automatic model_step(input bit m, input bit n, input bit r, input bit rdy);
        bit     push, pop, full, valid;
        entry_t e;
        valid   = (mq.size() != 0);
        push    = m | n;
        pop     = valid && rdy;
        full    = (mq.size() == DEPTH);
        e.match = m;
        e.l1n   = r ? '0 : L1N_W'(l1n_m);
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (full && !pop) ovf_m = 1'b1;
            else mq.push_back(e);
            l1n_m = (int'(e.l1n) + 1) % L1N_MOD;
        end else if (r) begin
            l1n_m = 0;
        end
        if (m && n) perr_m = 1'b1;
        if (valid && !rdy) begin
            run_m++;
            if (run_m >= STALL_CYC) stall_m = 1'b1;
        end else begin
            run_m = 0;
        end
    endtask

    task automatic check_outputs();
        check_eq("evt_valid", 32'(bus.EVT_VALID), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            check_eq("evt_match", 32'(bus.EVT_MATCH), 32'(mq[0].match));
            check_eq("evt_l1n", 32'(bus.EVT_L1N), 32'(mq[0].l1n));
        end
        check_eq("count", 32'(COUNT), 32'(mq.size()));
        check_eq("full", 32'(FULL), 32'(mq.size() == DEPTH));
        check_eq("overflow", 32'(OVERFLOW), 32'(ovf_m));
        check_eq("prot_err", 32'(PROT_ERR), 32'(perr_m));
        check_eq("stall", 32'(STALL), 32'(stall_m));
    endtask

    // Inputs change 1 time unit after the active edge; outputs sampled 1 unit after it.
    task automatic drive_cycle(input bit m, input bit n, input bit r, input bit rdy);
        bus.MATCHR    = m;
        bus.NO_MATCH  = n;
        bus.L1N_RST   = r;
        bus.EVT_READY = rdy;
        @(posedge CLK);
        model_step(m, n, r, rdy);
        #1;
        check_outputs();
    endtask

    // Asserts reset mid-cycle and checks the outputs clear before any edge.
    task automatic do_reset();
        #2;
        RST           = 1'b1;
        bus.MATCHR    = 1'b0;
        bus.NO_MATCH  = 1'b0;
        bus.L1N_RST   = 1'b0;
        bus.EVT_READY = 1'b0;
        #1;
        check_eq("rst_valid", 32'(bus.EVT_VALID), 32'd0);
        check_eq("rst_match", 32'(bus.EVT_MATCH), 32'd0);
        check_eq("rst_l1n", 32'(bus.EVT_L1N), 32'd0);
        check_eq("rst_count", 32'(COUNT), 32'd0);
        check_eq("rst_flags", 32'({FULL, OVERFLOW, PROT_ERR, STALL}), 32'd0);
        model_clear();
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        bus.MATCHR    = 1'b0;
        bus.NO_MATCH  = 1'b0;
        bus.L1N_RST   = 1'b0;
        bus.EVT_READY = 1'b0;
        model_clear();
        repeat (2) @(posedge CLK);
        #1;
        do_reset();

        // Basic path
        drive_cycle(1, 0, 0, 1);
        check_eq("basic_v0", 32'(bus.EVT_VALID), 32'd1);
        check_eq("basic_e0", 32'({bus.EVT_MATCH, bus.EVT_L1N}), 32'h1000);
        drive_cycle(0, 0, 0, 1);
        drive_cycle(0, 0, 0, 1);
        drive_cycle(0, 1, 0, 1);
        check_eq("basic_e1", 32'({bus.EVT_VALID, bus.EVT_MATCH, bus.EVT_L1N}), 32'h2001);
        drive_cycle(0, 0, 0, 1);
        check_eq("basic_cnt", 32'(COUNT), 32'd0);

        // Backpressure and overflow
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive_cycle(1, 0, 0, 0);
            if (i == 7) check_eq("bp_full8", 32'(FULL), 32'd1);
        end
        check_eq("bp_ovf", 32'(OVERFLOW), 32'd1);
        check_eq("bp_cnt", 32'(COUNT), 32'd8);
        for (int i = 0; i < 8; i++) drive_cycle(0, 0, 0, 1);
        drive_cycle(1, 0, 0, 1);
        check_eq("bp_next_l1n", 32'(bus.EVT_L1N), 32'd9);

        // Full plus simultaneous pop
        do_reset();
        for (int i = 0; i < 8; i++) drive_cycle(1, 0, 0, 0);
        drive_cycle(1, 0, 0, 1);
        check_eq("fp_cnt", 32'(COUNT), 32'd8);
        check_eq("fp_ovf", 32'(OVERFLOW), 32'd0);
        for (int i = 0; i < 7; i++) drive_cycle(0, 0, 0, 1);
        check_eq("fp_last", 32'(bus.EVT_L1N), 32'd8);
        drive_cycle(0, 0, 0, 1);

        // L1N wrap and synchronous L1N reset
        do_reset();
        for (int i = 0; i < 4095; i++) drive_cycle(1, 0, 0, 1);
        drive_cycle(1, 0, 0, 1);
        check_eq("wrap_fff", 32'(bus.EVT_L1N), 32'hFFF);
        drive_cycle(1, 0, 0, 1);
        check_eq("wrap_000", 32'(bus.EVT_L1N), 32'h000);
        drive_cycle(0, 1, 1, 1);
        check_eq("l1nrst_0", 32'({bus.EVT_MATCH, bus.EVT_L1N}), 32'h0000);
        drive_cycle(1, 0, 0, 1);
        check_eq("l1nrst_1", 32'(bus.EVT_L1N), 32'h001);

        // Protocol error
        do_reset();
        drive_cycle(1, 1, 0, 1);
        check_eq("perr_flag", 32'(PROT_ERR), 32'd1);
        check_eq("perr_entry", 32'({bus.EVT_MATCH, bus.EVT_L1N}), 32'h1000);
        drive_cycle(0, 1, 0, 1);
        check_eq("perr_next", 32'(bus.EVT_L1N), 32'd1);

        // Stall timeout, then asynchronous reset
        do_reset();
        drive_cycle(1, 0, 0, 0);
        for (int i = 0; i < STALL_CYC - 1; i++) drive_cycle(0, 0, 0, 0);
        check_eq("stall_pre", 32'(STALL), 32'd0);
        drive_cycle(0, 0, 0, 0);
        check_eq("stall_set", 32'(STALL), 32'd1);
        do_reset();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive_cycle(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3),
                        ($urandom_range(0, 99) < 3), ($urandom_range(0, 9) < 4));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
